reg_addr_sequencer: RTL and testbench

Parametrised, registered source for register-file read address 2 (RA2) in the ARM datapath. In single-transfer mode it selects Rm or Rd by RegSrc, as the decode stage requires. In block-transfer mode (LDM/STM) it walks a register-list bitmask and issues one register address per cycle. It sits between the instruction decoder and the register file read port, and stalls with the pipeline.

---
 rtl/reg_addr_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_reg_addr_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_addr_sequencer.sv
// reg_addr_sequencer
// Registered source for register-file read address 2 (RA2).
//   Single mode : RA2 follows RegSrc ? Rd : zero-extended Rm, one cycle late.
//   Block mode  : walks a captured LDM/STM register list, one address per cycle,
//                 lowest-first (Ascend=1) or highest-first (Ascend=0).
// Optional feature macro: ADDR_SEQ_WB_EN adds WbOffset = 4 * popcount(RegList),
// captured when a Start is accepted.
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   Rm, Rd, RegSrc    single-mode address sources and select
//   Start, RegList,   block-transfer request, list bitmask, direction;
//   Ascend            all sampled only when idle and not stalled
//   Stall             freezes every register
//   RA2               registered read address
//   Busy              block transfer in progress
//   Done              last list address on RA2, or empty-list completion
//   Count             zero-based transfer index
//   WbOffset          writeback byte offset (ADDR_SEQ_WB_EN only)
//
// state | meaning
// IDLE  | single-mode addressing, waiting for Start
// SEQ   | issuing list addresses; leaves once the remaining list is empty
module reg_addr_sequencer #(
  parameter int ADDR_W = 5,
  parameter int RM_W   = 4,
  parameter int LIST_W = 16,
  parameter int CNT_W  = $clog2(LIST_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RM_W-1:0]   Rm,
  input  logic [ADDR_W-1:0] Rd,
  input  logic              RegSrc,
  input  logic              Start,
  input  logic [LIST_W-1:0] RegList,
  input  logic              Ascend,
  input  logic              Stall,
  output logic [ADDR_W-1:0] RA2,
  output logic              Busy,
  output logic              Done,
  output logic [CNT_W-1:0]  Count
`ifdef ADDR_SEQ_WB_EN
  ,
  output logic [CNT_W+1:0]  WbOffset
`endif
);

  typedef enum logic {IDLE = 1'b0, SEQ = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [LIST_W-1:0]  list_q, list_d;
  logic               asc_q, asc_d;
  logic [ADDR_W-1:0]  ra2_q, ra2_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [ADDR_W-1:0]  single_addr;
  logic [ADDR_W-1:0]  start_addr;
  logic [ADDR_W-1:0]  seq_addr;
  logic [LIST_W-1:0]  start_rest;
  logic [LIST_W-1:0]  seq_rest;

  // Priority encoder: last assignment wins, so the scan order picks the winner.
  function automatic logic [ADDR_W-1:0] pick_addr(input logic [LIST_W-1:0] lst,
                                                  input logic              asc);
    pick_addr = '0;
    for (int i = 0; i < LIST_W; i++) begin
      if (asc) begin
        if (lst[LIST_W-1-i]) pick_addr = ADDR_W'(LIST_W - 1 - i);
      end else begin
        if (lst[i]) pick_addr = ADDR_W'(i);
      end
    end
  endfunction

  assign single_addr = RegSrc ? Rd : ADDR_W'(Rm);
  assign start_addr  = pick_addr(RegList, Ascend);
  assign start_rest  = RegList & ~(LIST_W'(1) << start_addr);
  assign seq_addr    = pick_addr(list_q, asc_q);
  assign seq_rest    = list_q & ~(LIST_W'(1) << seq_addr);

`ifdef ADDR_SEQ_WB_EN
  logic [CNT_W+1:0] wb_q, wb_d;

  function automatic logic [CNT_W-1:0] popcount(input logic [LIST_W-1:0] lst);
    popcount = '0;
    for (int i = 0; i < LIST_W; i++) begin
      popcount = popcount + CNT_W'(lst[i]);
    end
  endfunction

  always_comb begin
    wb_d = wb_q;
    if (!Stall && state_q == IDLE && Start) begin
      // Empty list yields popcount 0, so the same expression covers it.
      wb_d = {popcount(RegList), 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wb_q <= '0;
    else        wb_q <= wb_d;
  end

  assign WbOffset = wb_q;
`endif

  always_comb begin
    state_d = state_q;
    list_d  = list_q;
    asc_d   = asc_q;
    ra2_d   = ra2_q;
    busy_d  = busy_q;
    done_d  = done_q;
    count_d = count_q;
    if (!Stall) begin
      unique case (state_q)
        IDLE: begin
          if (Start && (RegList != '0)) begin
            asc_d   = Ascend;
            list_d  = start_rest;
            ra2_d   = start_addr;
            count_d = '0;
            busy_d  = 1'b1;
            done_d  = (start_rest == '0);
            state_d = SEQ;
          end else begin
            // Start with an empty list completes at once without leaving IDLE.
            ra2_d   = single_addr;
            busy_d  = 1'b0;
            done_d  = Start;
            count_d = '0;
          end
        end
        SEQ: begin
          if (list_q != '0) begin
            list_d  = seq_rest;
            ra2_d   = seq_addr;
            count_d = count_q + CNT_W'(1);
            done_d  = (seq_rest == '0);
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            ra2_d   = single_addr;
            count_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      list_q  <= '0;
      asc_q   <= 1'b0;
      ra2_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      asc_q   <= asc_d;
      ra2_q   <= ra2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign RA2   = ra2_q;
  assign Busy  = busy_q;
  assign Done  = done_q;
  assign Count = count_q;

endmodule

// File: tb/tb_reg_addr_sequencer.sv
module tb_reg_addr_sequencer;

  logic        clk;
  logic        rst_n;
  logic [3:0]  Rm;
  logic [4:0]  Rd;
  logic        RegSrc;
  logic        Start;
  logic [15:0] RegList;
  logic        Ascend;
  logic        Stall;
  logic [4:0]  RA2;
  logic        Busy;
  logic        Done;
  logic [4:0]  Count;
`ifdef ADDR_SEQ_WB_EN
  logic [6:0]  WbOffset;
`endif

  reg_addr_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Rm      (Rm),
    .Rd      (Rd),
    .RegSrc  (RegSrc),
    .Start   (Start),
    .RegList (RegList),
    .Ascend  (Ascend),
    .Stall   (Stall),
    .RA2     (RA2),
    .Busy    (Busy),
    .Done    (Done),
    .Count   (Count)
`ifdef ADDR_SEQ_WB_EN
    ,
    .WbOffset(WbOffset)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] ra2;
    logic       busy;
    logic       done;
    logic [4:0] count;
    logic [6:0] wb;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   addr_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk("RA2", 32'(RA2), 32'(e.ra2));
    chk("Busy", 32'(Busy), 32'(e.busy));
    chk("Done", 32'(Done), 32'(e.done));
    chk("Count", 32'(Count), 32'(e.count));
`ifdef ADDR_SEQ_WB_EN
    chk("WbOffset", 32'(WbOffset), 32'(e.wb));
`endif
  endtask

  // Reference model: a transfer is the ordered list of set-bit indices,
  // issued one per unstalled cycle, followed by one return-to-idle cycle.
  task automatic model_step();
    exp_t       nx;
    logic [4:0] single;
    nx = cur;
    single = RegSrc ? Rd : {1'b0, Rm};
    if (!Stall) begin
      if (!cur.busy) begin
        if (Start && RegList != 16'h0) begin
          addr_q.delete();
          for (int i = 0; i < 16; i++) begin
            int idx;
            idx = Ascend ? i : 15 - i;
            if (RegList[idx]) addr_q.push_back(idx);
          end
          nx.wb    = 7'(4 * addr_q.size());
          nx.ra2   = 5'(addr_q.pop_front());
          nx.count = 5'd0;
          nx.busy  = 1'b1;
          nx.done  = (addr_q.size() == 0);
        end else begin
          nx.ra2   = single;
          nx.busy  = 1'b0;
          nx.done  = Start;
          nx.count = 5'd0;
          if (Start) nx.wb = 7'd0;
        end
      end else if (addr_q.size() != 0) begin
        nx.ra2   = 5'(addr_q.pop_front());
        nx.count = cur.count + 5'd1;
        nx.done  = (addr_q.size() == 0);
      end else begin
        nx.ra2   = single;
        nx.busy  = 1'b0;
        nx.done  = 1'b0;
        nx.count = 5'd0;
      end
    end
    cur = nx;
    exp_q.push_back(nx);
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic cyc();
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    Start = 1'b0;
    #1;
    cur = '{ra2: 5'd0, busy: 1'b0, done: 1'b0, count: 5'd0, wb: 7'd0};
    addr_q.delete();
    chk_all(cur);
    exp_q.push_back(cur);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_all(e);
      end
    end
  end

  initial begin : driver
    rst_n = 1'b0; Rm = 4'h0; Rd = 5'h0; RegSrc = 1'b0;
    Start = 1'b0; RegList = 16'h0; Ascend = 1'b1; Stall = 1'b0;
    cur = '{ra2: 5'd0, busy: 1'b0, done: 1'b0, count: 5'd0, wb: 7'd0};
    @(negedge clk);
    do_reset();

    // Single mode.
    Rm = 4'hA; Rd = 5'h13; RegSrc = 1'b0;
    cyc(); cyc();
    RegSrc = 1'b1;
    cyc(); cyc();

    // Ascending 0,4,5,15.
    Start = 1'b1; RegList = 16'h8031; Ascend = 1'b1;
    cyc();
    Start = 1'b0;
    repeat (5) cyc();

    // Descending with a two-cycle stall in cycle 2.
    Start = 1'b1; Ascend = 1'b0;
    cyc();
    Start = 1'b0;
    cyc();
    Stall = 1'b1;
    cyc(); cyc();
    Stall = 1'b0;
    repeat (5) cyc();

    // Empty list.
    Start = 1'b1; RegList = 16'h0;
    cyc();
    Start = 1'b0;
    cyc(); cyc();

    // Start during SEQ is ignored, then a full list.
    Start = 1'b1; RegList = 16'h0124; Ascend = 1'b1;
    cyc();
    Start = 1'b1; RegList = 16'hFFFF; Ascend = 1'b0;
    cyc();
    Start = 1'b0;
    repeat (3) cyc();
    Start = 1'b1; RegList = 16'hFFFF; Ascend = 1'b1;
    cyc();
    Start = 1'b0;
    repeat (18) cyc();

    // Reset mid-transfer.
    Start = 1'b1; RegList = 16'h8031;
    cyc();
    Start = 1'b0;
    cyc();
    do_reset();
    RegSrc = 1'b1; Rd = 5'h1C;
    cyc();
    RegSrc = 1'b0; Rm = 4'h7;
    cyc(); cyc();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        Rm     = 4'($urandom);
        Rd     = 5'($urandom);
        RegSrc = 1'($urandom);
        Ascend = 1'($urandom);
        Stall  = ($urandom_range(0, 4) == 0);
        Start  = ($urandom_range(0, 5) == 0);
        case ($urandom_range(0, 7))
          0:       RegList = 16'h0;
          1:       RegList = 16'hFFFF;
          2:       RegList = 16'h1 << $urandom_range(0, 15);
          default: RegList = 16'($urandom);
        endcase
        cyc();
      end
    end

    Start = 1'b0; Stall = 1'b0;
    cyc();
    @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
